mem_access_stage: RTL and testbench

// MEM stage directly downstream of EX: consumes op/regcData/regcAddr/regcWr/memAddr/memData/excptype from EX,

---
 rtl/mem_access_stage_if.sv | 20 ++
 rtl/mem_access_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
// A request is held until a single-cycle ack; read data is valid with the ack.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs Lw/Sw/Ll/Sc over a req/ack memory bus, holds the LL/SC link
// bit, registers the write-back result for WB and stalls EX/ID while an access is pending.
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op_i,
  input  logic [31:0] regcData_i,
  input  logic [4:0]  regcAddr_i,
  input  logic        regcWr_i,
  input  logic [31:0] memAddr_i,
  input  logic [31:0] memData_i,
  input  logic [31:0] excptype_i,
  mem_access_stage_if.master bus,
  output logic [31:0] regData,
  output logic [4:0]  regAddr,
  output logic        regWr,
  output logic [5:0]  op_o,
  output logic        stall_o,
  output logic        llbit_o,
  output logic        align_err,
  output logic        bus_err
);

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_LL  = 6'h30;
  localparam logic [5:0] OP_SC  = 6'h38;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      regData_q, regData_d;
  logic [4:0]       regAddr_q, regAddr_d;
  logic             regWr_q, regWr_d;
  logic [5:0]       op_q, op_d;
  logic             llbit_q, llbit_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [5:0]       pop_q, pop_d;
  logic [4:0]       pdst_q, pdst_d;
  logic             pwr_q, pwr_d;
  logic             align_q, align_d;
  logic             buserr_q, buserr_d;
  logic             stall;
  logic             is_mem;

  assign is_mem = (op_i == OP_LW) || (op_i == OP_SW) || (op_i == OP_LL) || (op_i == OP_SC);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    regData_d = regData_q;
    regAddr_d = regAddr_q;
    regWr_d   = regWr_q;
    op_d      = op_q;
    llbit_d   = llbit_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    pop_d     = pop_q;
    pdst_d    = pdst_q;
    pwr_d     = pwr_q;
    align_d   = 1'b0;
    buserr_d  = 1'b0;
    stall     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Exception squash outranks everything, including a pending Sc's link check.
        if (excptype_i != 32'd0) begin
          regWr_d = 1'b0;
          op_d    = OP_NOP;
          llbit_d = 1'b0;
        end else if (!is_mem) begin
          regData_d = regcData_i;
          regAddr_d = regcAddr_i;
          regWr_d   = regcWr_i;
          op_d      = op_i;
        end else if (memAddr_i[1:0] != 2'b00) begin
          align_d = 1'b1;
          regWr_d = 1'b0;
          op_d    = OP_NOP;
        end else if ((op_i == OP_SC) && !llbit_q) begin
          regData_d = 32'd0;
          regAddr_d = regcAddr_i;
          regWr_d   = regcWr_i;
          op_d      = op_i;
        end else begin
          stall   = 1'b1;
          addr_d  = memAddr_i;
          wdata_d = memData_i;
          pop_d   = op_i;
          pdst_d  = regcAddr_i;
          pwr_d   = regcWr_i;
          we_d    = (op_i == OP_SW) || (op_i == OP_SC);
          cnt_d   = '0;
          regWr_d = 1'b0;
          op_d    = OP_NOP;
          state_d = ST_ACCESS;
        end
      end
      default: begin
        regWr_d = 1'b0;
        if (bus.mem_ack) begin
          state_d   = ST_IDLE;
          we_d      = 1'b0;
          regAddr_d = pdst_q;
          regWr_d   = pwr_q;
          op_d      = pop_q;
          case (pop_q)
            OP_SW: begin
              regData_d = 32'd0;
              regWr_d   = 1'b0;
            end
            OP_SC: begin
              regData_d = 32'd1;
              llbit_d   = 1'b0;
            end
            OP_LL: begin
              regData_d = bus.mem_rdata;
              llbit_d   = 1'b1;
            end
            default: regData_d = bus.mem_rdata;
          endcase
        end else if (cnt_q == TO_LAST) begin
          // Abandon the access; a late ack lands in IDLE and is ignored.
          buserr_d = 1'b1;
          we_d     = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      regData_q <= 32'd0;
      regAddr_q <= 5'd0;
      regWr_q   <= 1'b0;
      op_q      <= OP_NOP;
      llbit_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      pop_q     <= OP_NOP;
      pdst_q    <= 5'd0;
      pwr_q     <= 1'b0;
      align_q   <= 1'b0;
      buserr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      regData_q <= regData_d;
      regAddr_q <= regAddr_d;
      regWr_q   <= regWr_d;
      op_q      <= op_d;
      llbit_q   <= llbit_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      pop_q     <= pop_d;
      pdst_q    <= pdst_d;
      pwr_q     <= pwr_d;
      align_q   <= align_d;
      buserr_q  <= buserr_d;
    end
  end

  assign bus.mem_req   = (state_q == ST_ACCESS);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign regData       = regData_q;
  assign regAddr       = regAddr_q;
  assign regWr         = regWr_q;
  assign op_o          = op_q;
  assign stall_o       = stall;
  assign llbit_o       = llbit_q;
  assign align_err     = align_q;
  assign bus_err       = buserr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: drives EX-side ops and a hand-scripted memory ack.
module tb_mem_access_stage;
  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_LL  = 6'h30;
  localparam logic [5:0] OP_SC  = 6'h38;
  localparam logic [31:0] EXC_COUNTINT = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic [31:0] regcData;
  logic [4:0]  regcAddr;
  logic        regcWr;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic [31:0] excptype;
  logic [31:0] regData;
  logic [4:0]  regAddr;
  logic        regWr;
  logic [5:0]  op_o;
  logic        stall_o;
  logic        llbit_o;
  logic        align_err;
  logic        bus_err;

  int n_pass  = 0;
  int n_total = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_i       (op),
    .regcData_i (regcData),
    .regcAddr_i (regcAddr),
    .regcWr_i   (regcWr),
    .memAddr_i  (memAddr),
    .memData_i  (memData),
    .excptype_i (excptype),
    .bus        (bus.master),
    .regData    (regData),
    .regAddr    (regAddr),
    .regWr      (regWr),
    .op_o       (op_o),
    .stall_o    (stall_o),
    .llbit_o    (llbit_o),
    .align_err  (align_err),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] o, input logic [31:0] d, input logic [4:0] a,
                       input logic w, input logic [31:0] ma, input logic [31:0] md);
    op = o; regcData = d; regcAddr = a; regcWr = w; memAddr = ma; memData = md;
  endtask

  task automatic test_reset();
    rst = 1'b1; excptype = 32'd0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    drive(OP_NOP, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    n_total++; if (regData !== 32'd0) $display("FAIL rst_regData got=%h exp=0", regData); else n_pass++;
    n_total++; if (regWr !== 1'b0) $display("FAIL rst_regWr got=%b exp=0", regWr); else n_pass++;
    n_total++; if (op_o !== OP_NOP) $display("FAIL rst_op got=%h exp=%h", op_o, OP_NOP); else n_pass++;
    n_total++; if (llbit_o !== 1'b0) $display("FAIL rst_llbit got=%b exp=0", llbit_o); else n_pass++;
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", bus.mem_req); else n_pass++;
    n_total++; if (stall_o !== 1'b0) $display("FAIL rst_stall got=%b exp=0", stall_o); else n_pass++;
  endtask

  task automatic test_passthrough();
    drive(OP_ADD, 32'h0000_0055, 5'd3, 1'b1, 32'h0000_0100, 32'd0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    n_total++; if (stall_o !== 1'b0) $display("FAIL pass_stall got=%b exp=0", stall_o); else n_pass++;
    tick();
    bus.mem_ack = 1'b0;
    n_total++; if (regData !== 32'h55) $display("FAIL pass_regData got=%h exp=55", regData); else n_pass++;
    n_total++; if ({regAddr, regWr} !== {5'd3, 1'b1}) $display("FAIL pass_dest got=%0d/%b exp=3/1", regAddr, regWr); else n_pass++;
    n_total++; if (op_o !== OP_ADD) $display("FAIL pass_op got=%h exp=%h", op_o, OP_ADD); else n_pass++;
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL pass_no_req got=%b exp=0", bus.mem_req); else n_pass++;
  endtask

  task automatic test_lw();
    int stalls = 0;
    drive(OP_LW, 32'd0, 5'd7, 1'b1, 32'h0000_0100, 32'd0);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        drive(OP_NOP, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
      end
      @(negedge clk);
      if (stall_o) stalls++;
      if (c == 1) begin
        n_total++; if (bus.mem_req !== 1'b1) $display("FAIL lw_req got=%b exp=1", bus.mem_req); else n_pass++;
        n_total++; if (bus.mem_addr !== 32'h100) $display("FAIL lw_addr got=%h exp=100", bus.mem_addr); else n_pass++;
        n_total++; if (regWr !== 1'b0) $display("FAIL lw_bubble got=%b exp=0", regWr); else n_pass++;
      end
      tick();
      bus.mem_ack = 1'b0;
    end
    n_total++; if (stalls != 4) $display("FAIL lw_stall_cycles got=%0d exp=4", stalls); else n_pass++;
    n_total++; if (regData !== 32'hDEAD_BEEF) $display("FAIL lw_regData got=%h exp=deadbeef", regData); else n_pass++;
    n_total++; if ({regAddr, regWr} !== {5'd7, 1'b1}) $display("FAIL lw_dest got=%0d/%b exp=7/1", regAddr, regWr); else n_pass++;
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL lw_req_drop got=%b exp=0", bus.mem_req); else n_pass++;
  endtask

  task automatic test_sw();
    drive(OP_SW, 32'd0, 5'd9, 1'b1, 32'h0000_0104, 32'h0000_1234);
    tick();
    n_total++; if (bus.mem_we !== 1'b1) $display("FAIL sw_we got=%b exp=1", bus.mem_we); else n_pass++;
    n_total++; if (bus.mem_wdata !== 32'h1234) $display("FAIL sw_wdata got=%h exp=1234", bus.mem_wdata); else n_pass++;
    n_total++; if (bus.mem_addr !== 32'h104) $display("FAIL sw_addr got=%h exp=104", bus.mem_addr); else n_pass++;
    bus.mem_ack = 1'b1;
    drive(OP_NOP, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    n_total++; if (stall_o !== 1'b0) $display("FAIL sw_ack_stall got=%b exp=0", stall_o); else n_pass++;
    tick();
    bus.mem_ack = 1'b0;
    n_total++; if (regWr !== 1'b0) $display("FAIL sw_regWr got=%b exp=0", regWr); else n_pass++;
    n_total++; if (op_o !== OP_SW) $display("FAIL sw_op got=%h exp=%h", op_o, OP_SW); else n_pass++;
  endtask

  task automatic do_ll(input logic [31:0] a);
    drive(OP_LL, 32'd0, 5'd2, 1'b1, a, 32'd0);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hAAAA_5555;
    drive(OP_NOP, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    tick();
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_ll_sc();
    do_ll(32'h0000_0200);
    n_total++; if (llbit_o !== 1'b1) $display("FAIL ll_llbit got=%b exp=1", llbit_o); else n_pass++;
    n_total++; if (regData !== 32'hAAAA_5555) $display("FAIL ll_regData got=%h exp=aaaa5555", regData); else n_pass++;
    drive(OP_SC, 32'd0, 5'd3, 1'b1, 32'h0000_0200, 32'd7);
    @(negedge clk);
    n_total++; if (stall_o !== 1'b1) $display("FAIL sc_stall got=%b exp=1", stall_o); else n_pass++;
    tick();
    n_total++; if ({bus.mem_req, bus.mem_we} !== 2'b11) $display("FAIL sc_req_we got=%b exp=11", {bus.mem_req, bus.mem_we}); else n_pass++;
    bus.mem_ack = 1'b1;
    drive(OP_NOP, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    n_total++; if (regData !== 32'd1) $display("FAIL sc_ok_regData got=%h exp=1", regData); else n_pass++;
    n_total++; if (llbit_o !== 1'b0) $display("FAIL sc_ok_llbit got=%b exp=0", llbit_o); else n_pass++;
    n_total++; if (regWr !== 1'b1) $display("FAIL sc_ok_regWr got=%b exp=1", regWr); else n_pass++;
    drive(OP_SC, 32'd0, 5'd3, 1'b1, 32'h0000_0200, 32'd7);
    @(negedge clk);
    n_total++; if (stall_o !== 1'b0) $display("FAIL sc2_stall got=%b exp=0", stall_o); else n_pass++;
    tick();
    drive(OP_NOP, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL sc2_req got=%b exp=0", bus.mem_req); else n_pass++;
    n_total++; if (regData !== 32'd0) $display("FAIL sc2_regData got=%h exp=0", regData); else n_pass++;
    n_total++; if (regWr !== 1'b1) $display("FAIL sc2_regWr got=%b exp=1", regWr); else n_pass++;
  endtask

  task automatic test_exception();
    do_ll(32'h0000_0300);
    n_total++; if (llbit_o !== 1'b1) $display("FAIL exc_ll got=%b exp=1", llbit_o); else n_pass++;
    drive(OP_ADD, 32'h0000_0099, 5'd4, 1'b1, 32'd0, 32'd0);
    excptype = EXC_COUNTINT;
    tick();
    excptype = 32'd0;
    n_total++; if (llbit_o !== 1'b0) $display("FAIL exc_llbit got=%b exp=0", llbit_o); else n_pass++;
    n_total++; if (regWr !== 1'b0) $display("FAIL exc_regWr got=%b exp=0", regWr); else n_pass++;
    n_total++; if (op_o !== OP_NOP) $display("FAIL exc_op got=%h exp=%h", op_o, OP_NOP); else n_pass++;
    drive(OP_SC, 32'd0, 5'd5, 1'b1, 32'h0000_0300, 32'd1);
    @(negedge clk);
    n_total++; if (stall_o !== 1'b0) $display("FAIL exc_sc_stall got=%b exp=0", stall_o); else n_pass++;
    tick();
    drive(OP_NOP, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL exc_sc_req got=%b exp=0", bus.mem_req); else n_pass++;
    n_total++; if (regData !== 32'd0) $display("FAIL exc_sc_regData got=%h exp=0", regData); else n_pass++;
  endtask

  task automatic test_align();
    drive(OP_LW, 32'd0, 5'd6, 1'b1, 32'h0000_0102, 32'd0);
    @(negedge clk);
    n_total++; if (stall_o !== 1'b0) $display("FAIL al_stall got=%b exp=0", stall_o); else n_pass++;
    tick();
    drive(OP_NOP, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    n_total++; if (align_err !== 1'b1) $display("FAIL al_pulse got=%b exp=1", align_err); else n_pass++;
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL al_req got=%b exp=0", bus.mem_req); else n_pass++;
    n_total++; if (regWr !== 1'b0) $display("FAIL al_regWr got=%b exp=0", regWr); else n_pass++;
    tick();
    n_total++; if (align_err !== 1'b0) $display("FAIL al_pulse_end got=%b exp=0", align_err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(OP_LW, 32'd0, 5'd10, 1'b1, 32'h0000_0500, 32'd0);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_1111;
    drive(OP_LW, 32'd0, 5'd11, 1'b1, 32'h0000_0504, 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    n_total++; if (regData !== 32'h1111_1111) $display("FAIL b2b_first got=%h exp=11111111", regData); else n_pass++;
    @(negedge clk);
    n_total++; if (stall_o !== 1'b1) $display("FAIL b2b_restall got=%b exp=1", stall_o); else n_pass++;
    tick();
    n_total++; if (bus.mem_addr !== 32'h504) $display("FAIL b2b_addr got=%h exp=504", bus.mem_addr); else n_pass++;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h2222_2222;
    drive(OP_NOP, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    n_total++; if ({regAddr, regData} !== {5'd11, 32'h2222_2222}) $display("FAIL b2b_second got=%0d/%h exp=11/22222222", regAddr, regData); else n_pass++;
  endtask

  task automatic test_timeout();
    int stalls = 0;
    drive(OP_LW, 32'd0, 5'd8, 1'b1, 32'h0000_0600, 32'd0);
    for (int c = 0; c <= 16; c++) begin
      if (c == 16) drive(OP_NOP, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      if (stall_o) stalls++;
      if (c == 16) begin
        n_total++; if (stall_o !== 1'b0) $display("FAIL to_release got=%b exp=0", stall_o); else n_pass++;
      end
      tick();
    end
    n_total++; if (stalls != 16) $display("FAIL to_stall_cycles got=%0d exp=16", stalls); else n_pass++;
    n_total++; if (bus_err !== 1'b1) $display("FAIL to_bus_err got=%b exp=1", bus_err); else n_pass++;
    n_total++; if ({bus.mem_req, regWr} !== 2'b00) $display("FAIL to_req_wr got=%b exp=00", {bus.mem_req, regWr}); else n_pass++;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5A5A_5A5A;
    tick();
    bus.mem_ack = 1'b0;
    n_total++; if (bus_err !== 1'b0) $display("FAIL to_pulse_end got=%b exp=0", bus_err); else n_pass++;
    n_total++; if (regData === 32'h5A5A_5A5A) $display("FAIL to_late_ack got=%h exp=not 5a5a5a5a", regData); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    drive(OP_ADD, 32'h0000_0077, 5'd1, 1'b1, 32'd0, 32'd0);
    tick();
    drive(OP_LW, 32'd0, 5'd5, 1'b1, 32'h0000_0400, 32'd0);
    tick(); tick();
    n_total++; if (bus.mem_req !== 1'b1) $display("FAIL rm_req_before got=%b exp=1", bus.mem_req); else n_pass++;
    rst = 1'b1;
    drive(OP_NOP, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL rm_req got=%b exp=0", bus.mem_req); else n_pass++;
    n_total++; if ({regData, regWr} !== 33'd0) $display("FAIL rm_wb got=%h/%b exp=0/0", regData, regWr); else n_pass++;
    n_total++; if (op_o !== OP_NOP) $display("FAIL rm_op got=%h exp=%h", op_o, OP_NOP); else n_pass++;
    n_total++; if (bus.mem_addr !== 32'd0) $display("FAIL rm_addr got=%h exp=0", bus.mem_addr); else n_pass++;
    tick();
    n_total++; if (regWr !== 1'b0) $display("FAIL rm_no_wb got=%b exp=0", regWr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lw();
    test_sw();
    test_ll_sc();
    test_exception();
    test_align();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
